// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding and default sizing.
package sw_debounce_pkg;

    // 10 ms of stability at 100 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

    // Encoding keeps bit 0 as "heading towards / settled high" and bit 1 as
    // "previously settled high", so the WAIT states are the odd-parity codes.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } db_state_t;

    function automatic logic is_wait(input db_state_t s);
        return (s == WAIT_HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/sw_debounce_pulse_sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit board input.
// Reusable for the other board switches and buttons.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic din,
    input  logic clk,
    input  logic rst_n,
    output logic dout
);

    logic [STAGES-1:0] q;

    // Shift the raw input through the flop chain; the oldest stage is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= {q[STAGES-2:0], din};
        end
    end

    assign dout = q[STAGES-1];

endmodule

// File: rtl/sw_debounce_pulse.sv
// Debounces one raw switch/button: synchronise, qualify with a stability counter,
// then present a clean level and single-cycle rise/fall pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE_LOW  | level settled low, watching for sync to go high
//   WAIT_HIGH | sync high, counting stable cycles before declaring a rise
//   IDLE_HIGH | level settled high, watching for sync to go low
//   WAIT_LOW  | sync low, counting stable cycles before declaring a fall
module sw_debounce_pulse
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync;
    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, rise_nxt, fall_nxt, busy_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .din   (sw_raw),
        .clk   (clk),
        .rst_n (rst_n),
        .dout  (sync)
    );

    // State, counter and all outputs are registered together so the pulses line up with the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            sw_level   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sw_level   <= level_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state logic: a WAIT state aborts on any disagreeing sample and commits
    // only once the counter reaches its last value; the counter therefore never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = sw_level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        case (state)
            IDLE_LOW: begin
                if (sync) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync) begin
                    state_nxt = IDLE_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!sync) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync) begin
                    state_nxt = IDLE_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase

        busy_nxt = is_wait(state_nxt);
    end

endmodule
